// File: rtl/pipeline_input_arbiter_pkg.sv
// Shared constants and types for the pipeline input arbiter and its owner-tag FIFO.
// The owner-tag FIFO depth is derived from the pipeline address space plus the output read latency.
package pipeline_input_arbiter_pkg;

    localparam int ADDR_WIDTH          = 32'sd9;
    localparam int OUTPUT_INDEX_OFFSET = 32'sd2;
    localparam int OUTPUT_READ_LATENCY = 32'sd4;

    // Smallest power of two that is not below value.
    function automatic int nextPow2(input int value);
        int result;
        result = 32'sd1;
        for (int i = 0; i < 31; i++) begin
            if (result < value) begin
                result = result * 32'sd2;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Every bot that can be in flight needs a tag slot.
    localparam int ARB_TAG_DEPTH =
        nextPow2((32'sd1 << ADDR_WIDTH) + OUTPUT_READ_LATENCY + (OUTPUT_INDEX_OFFSET * 32'sd0));

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifoOp_e;

endpackage

// File: rtl/pipeline_input_arbiter_owner_tag_fifo.sv
// Owner-tag FIFO: block-RAM storage with a prefetched head, so the head is valid without a read bubble.
// A pop on an empty FIFO is ignored; a same-cycle push into an empty FIFO is not visible to that pop.
module pipeline_input_arbiter_owner_tag_fifo
    import pipeline_input_arbiter_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] ramQ_r;
    logic [WIDTH-1:0] bypassData_r;
    logic             bypass_r;
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [PTR_W-1:0] rdAddr_s;
    logic [CNT_W-1:0] count_r;
    logic             pushEff_s;
    logic             popEff_s;
    fifoOp_e          op_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign head  = bypass_r ? bypassData_r : ramQ_r;

    // Effective operations and the look-ahead read address for next cycle's head.
    always_comb begin
        pushEff_s = push & ~full;
        popEff_s  = pop & ~empty;
        op_s      = fifoOp_e'({popEff_s, pushEff_s});
        if (popEff_s) begin
            rdAddr_s = rdPtr_r + PTR_W'(1);
        end else begin
            rdAddr_s = rdPtr_r;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (op_s)
                FIFO_PUSH: begin
                    wrPtr_r <= wrPtr_r + PTR_W'(1);
                    count_r <= count_r + CNT_W'(1);
                end
                FIFO_POP: begin
                    rdPtr_r <= rdPtr_r + PTR_W'(1);
                    count_r <= count_r - CNT_W'(1);
                end
                FIFO_BOTH: begin
                    wrPtr_r <= wrPtr_r + PTR_W'(1);
                    rdPtr_r <= rdPtr_r + PTR_W'(1);
                end
                default: begin
                    wrPtr_r <= wrPtr_r;
                    rdPtr_r <= rdPtr_r;
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Tag storage; the registered read is the prefetch of the next head.
    always_ff @(posedge clk) begin
        if (pushEff_s) begin
            mem_r[wrPtr_r] <= pushData;
        end
        ramQ_r <= mem_r[rdAddr_s];
    end

    // A tag written to the slot being prefetched bypasses the RAM's old read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_r     <= 1'b0;
            bypassData_r <= {WIDTH{1'b0}};
        end else begin
            bypass_r     <= pushEff_s && (wrPtr_r == rdAddr_s);
            bypassData_r <= pushData;
        end
    end

endmodule

// File: rtl/pipeline_input_arbiter.sv
// Round-robin arbiter sharing one bot pipeline among NUM_REQ sources, routing results back via owner tags.
// Optional macro PIPELINE_ARBITER_STATS_EN adds saturating per-source accepted-bot counters (acceptCount).
module pipeline_input_arbiter
    import pipeline_input_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_DEPTH  = ARB_TAG_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic                          botOutValid,
    output logic [DATA_WIDTH-1:0]         botOutData,
    input  logic                          managerReady,
    input  logic                          resultValid,
    output logic [NUM_REQ-1:0]            resultRoute,
    output logic                          tagUnderflow
`ifdef PIPELINE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         acceptCount
`endif
);

    localparam int TAG_W = $clog2(NUM_REQ);

    logic [TAG_W-1:0] rrPtr_r;
    logic [TAG_W-1:0] winnerIdx_s;
    logic             winnerFound_s;
    logic [TAG_W:0]   candSum_s;
    logic [TAG_W-1:0] candIdx_s;
    logic             accept_s;
    logic             tagFull_s;
    logic             tagEmpty_s;
    logic [TAG_W-1:0] tagHead_s;

    function automatic logic [NUM_REQ-1:0] toOneHot(input logic [TAG_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin search starting at rrPtr with explicit wrap at NUM_REQ.
    always_comb begin
        winnerIdx_s   = {TAG_W{1'b0}};
        winnerFound_s = 1'b0;
        candSum_s     = {(TAG_W+1){1'b0}};
        candIdx_s     = {TAG_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            candSum_s = {1'b0, rrPtr_r} + (TAG_W+1)'(k);
            if (candSum_s >= (TAG_W+1)'(NUM_REQ)) begin
                candSum_s = candSum_s - (TAG_W+1)'(NUM_REQ);
            end else begin
                candSum_s = candSum_s;
            end
            candIdx_s = candSum_s[TAG_W-1:0];
            if (!winnerFound_s && reqValid[candIdx_s]) begin
                winnerFound_s = 1'b1;
                winnerIdx_s   = candIdx_s;
            end else begin
                winnerIdx_s   = winnerIdx_s;
            end
        end
    end

    // Handshake towards the sources and the manager; everything is held low during reset.
    always_comb begin
        botOutValid = 1'b0;
        botOutData  = {DATA_WIDTH{1'b0}};
        reqReady    = {NUM_REQ{1'b0}};
        accept_s    = 1'b0;
        if (rst) begin
            botOutValid = 1'b0;
        end else begin
            botOutValid = (|reqValid) & ~tagFull_s;
            botOutData  = reqData[int'(winnerIdx_s) * DATA_WIDTH +: DATA_WIDTH];
            accept_s    = botOutValid & managerReady;
            if (accept_s) begin
                reqReady = toOneHot(winnerIdx_s);
            end else begin
                reqReady = {NUM_REQ{1'b0}};
            end
        end
    end

    // Round-robin pointer moves just past the accepted source.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_r <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            if (winnerIdx_s == TAG_W'(NUM_REQ - 1)) begin
                rrPtr_r <= {TAG_W{1'b0}};
            end else begin
                rrPtr_r <= winnerIdx_s + TAG_W'(1);
            end
        end else begin
            rrPtr_r <= rrPtr_r;
        end
    end

    pipeline_input_arbiter_owner_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_ownerTagFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept_s),
        .pushData (winnerIdx_s),
        .pop      (resultValid),
        .full     (tagFull_s),
        .empty    (tagEmpty_s),
        .head     (tagHead_s)
    );

    // Result routing pulse and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            resultRoute  <= {NUM_REQ{1'b0}};
            tagUnderflow <= 1'b0;
        end else begin
            if (resultValid && !tagEmpty_s) begin
                resultRoute <= toOneHot(tagHead_s);
            end else begin
                resultRoute <= {NUM_REQ{1'b0}};
            end
            if (resultValid && tagEmpty_s) begin
                tagUnderflow <= 1'b1;
            end else begin
                tagUnderflow <= tagUnderflow;
            end
        end
    end

`ifdef PIPELINE_ARBITER_STATS_EN
    logic [31:0] acceptCount_r [NUM_REQ];

    // Saturating per-source accept counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                acceptCount_r[i] <= 32'd0;
            end else if (reqReady[i] && (acceptCount_r[i] != 32'hFFFF_FFFF)) begin
                acceptCount_r[i] <= acceptCount_r[i] + 32'd1;
            end else begin
                acceptCount_r[i] <= acceptCount_r[i];
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        acceptCount = {(NUM_REQ*32){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            acceptCount[i*32 +: 32] = acceptCount_r[i];
        end
    end
`endif

endmodule
